// File: rtl/ex_alu1_iter_if.sv
// Handshake and operand/result bundle between the EX operand muxes and the
// iterative compare/shift slice.
interface ex_alu1_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic            is_signed;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic            branch;
  logic            slt;
  logic [XLEN-1:0] shift;

  modport master (
    output in_valid, alu_op, is_signed, a, b, out_ready,
    input  in_ready, out_valid, branch, slt, shift
  );

  modport slave (
    input  in_valid, alu_op, is_signed, a, b, out_ready,
    output in_ready, out_valid, branch, slt, shift
  );
endinterface

// File: rtl/ex_alu1_iter.sv
// EX-stage compare/shift slice: single-cycle branch compares and SLT,
// iterative SLL/SRL/SRA moving at most STEP bit positions per cycle.
module ex_alu1_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_alu1_iter_if.slave     bus
);

  localparam int unsigned SHW     = $clog2(XLEN);
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  localparam logic [3:0] ALU_BEQ = 4'h0;
  localparam logic [3:0] ALU_BNE = 4'h1;
  localparam logic [3:0] ALU_SLT = 4'h2;
  localparam logic [3:0] ALU_BLT = 4'h4;
  localparam logic [3:0] ALU_BGE = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h8;
  localparam logic [3:0] ALU_SRL = 4'h9;
  localparam logic [3:0] ALU_SRA = 4'hA;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] shift_q, shift_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [3:0]      op_q, op_d;
  logic            fill_q, fill_d;
  logic            branch_q, branch_d;
  logic            slt_q, slt_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // The step shifter is shared: it takes the fresh operand at accept and the
  // working register afterwards, so the first step overlaps the accept cycle.
  logic [XLEN-1:0] src_c;
  logic [SHW-1:0]  amt_c;
  logic [SHW-1:0]  step_c;
  logic [SHW-1:0]  rem_after_c;
  logic [3:0]      sop_c;
  logic            fill_c;
  logic [XLEN-1:0] shifted_c;

  always_comb begin
    if (state_q == IDLE) begin
      src_c  = bus.a;
      amt_c  = bus.b[SHW-1:0];
      sop_c  = bus.alu_op;
      fill_c = bus.a[XLEN-1];
    end else begin
      src_c  = shift_q;
      amt_c  = rem_q;
      sop_c  = op_q;
      fill_c = fill_q;
    end

    if ({1'b0, amt_c} > STEP_W) step_c = SHW'(STEP);
    else                        step_c = amt_c;
    rem_after_c = amt_c - step_c;

    case (sop_c)
      ALU_SLL: shifted_c = src_c << step_c;
      ALU_SRA: shifted_c = (src_c >> step_c) |
                           (fill_c ? ~({XLEN{1'b1}} >> step_c) : '0);
      default: shifted_c = src_c >> step_c;
    endcase
  end

  // Compare on a zero-extended difference; signed lt corrects for overflow.
  logic [XLEN:0] diff_c;
  logic          eq_c;
  logic          ovf_c;
  logic          lt_c;

  always_comb begin
    diff_c = {1'b0, bus.a} - {1'b0, bus.b};
    eq_c   = (diff_c[XLEN-1:0] == '0);
    ovf_c  = (bus.a[XLEN-1] ^ bus.b[XLEN-1]) & (bus.a[XLEN-1] ^ diff_c[XLEN-1]);
    lt_c   = bus.is_signed ? (diff_c[XLEN-1] ^ ovf_c) : diff_c[XLEN];
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    op_d        = op_q;
    fill_d      = fill_q;
    branch_d    = branch_q;
    slt_d       = slt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (flush) begin
      state_d     = IDLE;
      shift_d     = '0;
      rem_d       = '0;
      op_d        = '0;
      fill_d      = 1'b0;
      branch_d    = 1'b0;
      slt_d       = 1'b0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d        = bus.alu_op;
            fill_d      = bus.a[XLEN-1];
            branch_d    = 1'b0;
            slt_d       = 1'b0;
            shift_d     = '0;
            rem_d       = '0;
            in_ready_d  = 1'b0;
            state_d     = DONE;
            out_valid_d = 1'b1;
            case (bus.alu_op)
              ALU_BEQ: branch_d = eq_c;
              ALU_BNE: branch_d = ~eq_c;
              ALU_BGE: branch_d = ~lt_c;
              ALU_BLT: branch_d = lt_c;
              ALU_SLT: slt_d    = lt_c;
              ALU_SLL, ALU_SRL, ALU_SRA: begin
                shift_d = shifted_c;
                rem_d   = rem_after_c;
                if (rem_after_c != '0) begin
                  state_d     = SHIFT;
                  out_valid_d = 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        SHIFT: begin
          shift_d = shifted_c;
          rem_d   = rem_after_c;
          if (rem_after_c == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      fill_q      <= 1'b0;
      branch_q    <= 1'b0;
      slt_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      fill_q      <= fill_d;
      branch_q    <= branch_d;
      slt_q       <= slt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // A same-cycle flush must block acceptance, hence the gate on in_ready.
  assign bus.in_ready  = in_ready_q & ~flush;
  assign bus.out_valid = out_valid_q;
  assign bus.branch    = branch_q;
  assign bus.slt       = slt_q;
  assign bus.shift     = shift_q;

endmodule
